// File: rtl/if_id_buffer_if.sv
// Handshake bundle between the fetch stage, the IF/ID buffer and the decode stage.
// The buffer owns the slave view; whatever drives fetch/decode owns the master view.
interface if_id_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;
  logic            flush;
  logic [1:0]      count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_instr, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer at the IF/ID boundary; presents a NOP bubble when empty.
// All outputs are decoded from registered state, so no input reaches an output combinationally.
module if_id_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst,
  if_id_buffer_if.slave bus
);

  logic [XLEN-1:0] pc_q    [2];
  logic [XLEN-1:0] instr_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      cnt;

  logic            not_full;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] head_pc;

  assign not_full  = (cnt != 2'd2);
  assign not_empty = (cnt != 2'd0);

  // Flush suppresses both sides of the handshake for the cycle it is asserted.
  assign push = bus.in_valid  && not_full  && !bus.flush;
  assign pop  = bus.out_ready && not_empty && !bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= bus.in_pc;
        instr_q[wr_ptr] <= bus.in_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        cnt <= cnt + 2'd1;
      end else if (pop && !push) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  assign head_pc          = not_empty ? pc_q[rd_ptr] : '0;
  assign bus.in_ready     = not_full;
  assign bus.out_valid    = not_empty;
  assign bus.out_pc       = head_pc;
  assign bus.out_instr    = not_empty ? instr_q[rd_ptr] : NOP_INSTR;
  assign bus.out_pc_plus4 = head_pc + XLEN'(4);
  assign bus.count        = cnt;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: driver keeps a FIFO reference model, a negedge
// monitor compares every presented output against it.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst;

  if_id_buffer_if #(.XLEN(32)) bus ();

  if_id_buffer #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t sb_q[$];
  int   model_cnt;
  int   n_cmp;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares state/outputs each negedge and retires the head on a handshake.
  always @(negedge clk) begin
    check("count", 32'(bus.count), 32'(model_cnt));
    check("out_valid", 32'(bus.out_valid), 32'(model_cnt != 0));
    check("in_ready", 32'(bus.in_ready), 32'(model_cnt != 2));
    if (model_cnt == 0) begin
      check("empty_pc", bus.out_pc, 32'h0);
      check("empty_instr", bus.out_instr, NOP);
      check("empty_pc4", bus.out_pc_plus4, 32'h4);
    end else if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry required %0d entries", model_cnt);
    end else begin
      check("head_pc", bus.out_pc, sb_q[0].pc);
      check("head_instr", bus.out_instr, sb_q[0].instr);
      check("head_pc4", bus.out_pc_plus4, sb_q[0].pc + 32'd4);
      if (rst && bus.out_ready && !bus.flush) begin
        void'(sb_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model applies the buffer rules at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic rdy, input logic fl);
    int push;
    int pop;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    if (!rst || fl) begin
      model_cnt = 0;
      sb_q.delete();
    end else begin
      push = (v && model_cnt != 2) ? 1 : 0;
      pop  = (rdy && model_cnt != 0) ? 1 : 0;
      if (push == 1) sb_q.push_back('{pc: pc, instr: instr});
      model_cnt = model_cnt + push - pop;
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    model_cnt = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held with in_valid high: nothing may be captured.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_instr", bus.out_instr, NOP);
    check("rst_pc4", bus.out_pc_plus4, 32'h4);
    rst = 1'b1;

    // Single transfer, then drain.
    step(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill and stall, then release decode while 0x8 is still offered.
    step(1'b1, 32'h0, 32'hA000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h4, 32'hA000_0004, 1'b0, 1'b0);
    step(1'b1, 32'h8, 32'hA000_0008, 1'b0, 1'b0);
    step(1'b1, 32'h8, 32'hA000_0008, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Continuous stream at occupancy 1.
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush at count 2 with push and pop both requested.
    step(1'b1, 32'h10, 32'hC000_0010, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'hC000_0014, 1'b0, 1'b0);
    step(1'b1, 32'h300, 32'hC000_0300, 1'b1, 1'b1);
    check("flush_count", 32'(bus.count), 32'h0);
    step(1'b1, 32'h200, 32'hC000_0200, 1'b1, 1'b0);
    check("post_flush_pc", bus.out_pc, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // PC+4 wrap.
    step(1'b1, 32'hFFFF_FFFC, 32'hD000_0000, 1'b0, 1'b0);
    check("wrap_pc4", bus.out_pc_plus4, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with the buffer full.
    step(1'b1, 32'h20, 32'hE000_0020, 1'b0, 1'b0);
    step(1'b1, 32'h24, 32'hE000_0024, 1'b0, 1'b0);
    check("pre_async_count", 32'(bus.count), 32'h2);
    #1 rst = 1'b0;
    #1;
    check("async_count", 32'(bus.count), 32'h0);
    check("async_valid", 32'(bus.out_valid), 32'h0);
    check("async_ready", 32'(bus.in_ready), 32'h1);
    check("async_instr", bus.out_instr, NOP);
    check("async_pc", bus.out_pc, 32'h0);
    check("async_pc4", bus.out_pc_plus4, 32'h4);
    model_cnt = 0;
    sb_q.delete();
    step(1'b1, 32'h28, 32'hE000_0028, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h2C, 32'hE000_002C, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), rnd_pc(), $urandom(),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
